// File: rtl/vscale_alu_sched.sv
// vscale_alu_sched: round-robin share of one ALU
// between port 0 (pipeline) and port 1 (aux/debug).
//
// Ports:
//   clk, reset_n          clock, async active-low reset
//   reqN_valid/ready      request handshake, N = 0/1
//   reqN_op/in1/in2       ALU op and operands
//   rsp_valid/ready       registered response handshake
//   rsp_data, rsp_id      ALU result and issuing port
//   grant_cnt0/1          saturating accept counters,
//                         present only when
//                         VSCALE_ALU_SCHED_PERF_EN is defined

`ifndef XPR_LEN
`define XPR_LEN 32
`endif
`ifndef SHAMT_WIDTH
`define SHAMT_WIDTH 5
`endif
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 4
`define ALU_OP_ADD  4'd0
`define ALU_OP_SLL  4'd1
`define ALU_OP_XOR  4'd4
`define ALU_OP_SRL  4'd5
`define ALU_OP_OR   4'd6
`define ALU_OP_AND  4'd7
`define ALU_OP_SEQ  4'd8
`define ALU_OP_SNE  4'd9
`define ALU_OP_SUB  4'd10
`define ALU_OP_SRA  4'd11
`define ALU_OP_SLT  4'd12
`define ALU_OP_SGE  4'd13
`define ALU_OP_SLTU 4'd14
`define ALU_OP_SGEU 4'd15
`endif

module vscale_alu_sched #(
  parameter logic RR_INIT = 1'b1
`ifdef VSCALE_ALU_SCHED_PERF_EN
  ,
  parameter int CNT_WIDTH = 16
`endif
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [`ALU_OP_WIDTH-1:0] req0_op,
  input  logic [`XPR_LEN-1:0]      req0_in1,
  input  logic [`XPR_LEN-1:0]      req0_in2,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [`ALU_OP_WIDTH-1:0] req1_op,
  input  logic [`XPR_LEN-1:0]      req1_in1,
  input  logic [`XPR_LEN-1:0]      req1_in2,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [`XPR_LEN-1:0]      rsp_data,
  output logic                     rsp_id
`ifdef VSCALE_ALU_SCHED_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0]     grant_cnt0,
  output logic [CNT_WIDTH-1:0]     grant_cnt1
`endif
);

  localparam int XL = `XPR_LEN;
  localparam int SW = `SHAMT_WIDTH;

  logic          rsp_valid_q, rsp_valid_d;
  logic [XL-1:0] rsp_data_q, rsp_data_d;
  logic          rsp_id_q, rsp_id_d;
  logic          last_q, last_d;

  logic gnt0, gnt1, slot_free;
  logic acc0, acc1, acc;

  logic [`ALU_OP_WIDTH-1:0] op_s;
  logic [XL-1:0]            in1_s, in2_s;
  logic [SW-1:0]            shamt;
  logic [XL-1:0]            alu_res;

  // A tie goes to the port that did not win last.
  assign gnt0 = req0_valid & (~req1_valid | last_q);
  assign gnt1 = req1_valid & (~req0_valid | ~last_q);

  assign slot_free  = ~rsp_valid_q | rsp_ready;
  assign req0_ready = gnt0 & slot_free;
  assign req1_ready = gnt1 & slot_free;

  assign acc0 = req0_valid & req0_ready;
  assign acc1 = req1_valid & req1_ready;
  assign acc  = acc0 | acc1;

  assign op_s  = gnt1 ? req1_op  : req0_op;
  assign in1_s = gnt1 ? req1_in1 : req0_in1;
  assign in2_s = gnt1 ? req1_in2 : req0_in2;
  assign shamt = in2_s[SW-1:0];

  always_comb begin
    alu_res = '0;
    case (op_s)
      `ALU_OP_ADD:  alu_res = in1_s + in2_s;
      `ALU_OP_SLL:  alu_res = in1_s << shamt;
      `ALU_OP_XOR:  alu_res = in1_s ^ in2_s;
      `ALU_OP_OR:   alu_res = in1_s | in2_s;
      `ALU_OP_AND:  alu_res = in1_s & in2_s;
      `ALU_OP_SRL:  alu_res = in1_s >> shamt;
      `ALU_OP_SEQ:
        alu_res = {{(XL-1){1'b0}}, in1_s == in2_s};
      `ALU_OP_SNE:
        alu_res = {{(XL-1){1'b0}}, in1_s != in2_s};
      `ALU_OP_SUB:  alu_res = in1_s - in2_s;
      `ALU_OP_SRA:
        alu_res = $signed(in1_s) >>> shamt;
      `ALU_OP_SLT:
        alu_res = {{(XL-1){1'b0}},
                   $signed(in1_s) < $signed(in2_s)};
      `ALU_OP_SGE:
        alu_res = {{(XL-1){1'b0}},
                   $signed(in1_s) >= $signed(in2_s)};
      `ALU_OP_SLTU:
        alu_res = {{(XL-1){1'b0}}, in1_s < in2_s};
      `ALU_OP_SGEU:
        alu_res = {{(XL-1){1'b0}}, in1_s >= in2_s};
      default:      alu_res = '0;
    endcase
  end

  // Without an accept, a taken result retires and a
  // stalled one holds; data/id are kept either way.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    last_d      = last_q;
    if (acc) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = alu_res;
      rsp_id_d    = acc1;
      last_d      = acc1;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= 1'b0;
      last_q      <= RR_INIT;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      last_q      <= last_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;

`ifdef VSCALE_ALU_SCHED_PERF_EN
  logic [CNT_WIDTH-1:0] cnt0_q, cnt0_d;
  logic [CNT_WIDTH-1:0] cnt1_q, cnt1_d;

  // Saturate at all-ones rather than wrap.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (acc0 && (cnt0_q != '1)) cnt0_d = cnt0_q + 1'b1;
    if (acc1 && (cnt1_q != '1)) cnt1_d = cnt1_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`endif

endmodule
